// File: rtl/pipe_average_pkg.sv
// Shared constants and helpers for the pipelined channel averager.
package pipe_average_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_NUM_CH = 8;
  localparam int NUM_CH_MIN = 2;
  localparam int NUM_CH_MAX = 32;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < v) r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/pipe_average_stage.sv
// One adder-tree level: PAIRS registered pairwise sums, widened by one bit, with a valid bit.
module pipe_average_stage
  import pipe_average_pkg::*;
#(
  parameter int IN_W  = DEF_DATA_W,
  parameter int PAIRS = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      adv,
  input  logic                      in_vld,
  input  logic [2*PAIRS*IN_W-1:0]   in_data,
  output logic                      vld_p,
  output logic [PAIRS*(IN_W+1)-1:0] sum_p
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p <= 1'b0;
    end else if (adv) begin
      vld_p <= in_vld;
    end
  end

  // Data is not reset: the valid bit alone decides whether a sum is meaningful.
  always_ff @(posedge clk) begin
    if (adv) begin
      for (int p = 0; p < PAIRS; p++) begin
        sum_p[p*(IN_W+1) +: (IN_W+1)] <= (IN_W+1)'(in_data[(2*p)*IN_W +: IN_W])
                                        + (IN_W+1)'(in_data[(2*p+1)*IN_W +: IN_W]);
      end
    end
  end

endmodule

// File: rtl/pipe_average.sv
// Pipelined average/sum of NUM_CH unsigned channels with a single global advance.
// Define PIPE_AVERAGE_ROUND_EN for round-half-up averaging; default build truncates.
module pipe_average
  import pipe_average_pkg::*;
#(
  parameter int  DATA_W  = DEF_DATA_W,
  parameter int  NUM_CH  = DEF_NUM_CH,
  localparam int LOG2_CH = clog2(NUM_CH),
  localparam int SUM_W   = DATA_W + LOG2_CH
) (
  input  logic                     Clk,
  input  logic                     Rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_avg,
  output logic [SUM_W-1:0]         out_sum
);

  if (NUM_CH < NUM_CH_MIN || NUM_CH > NUM_CH_MAX || (NUM_CH & (NUM_CH - 1)) != 0) begin : g_bad_num_ch
    $error("pipe_average: NUM_CH must be a power of two in 2..32");
  end

  function automatic logic [DATA_W-1:0] avg_of(input logic [SUM_W-1:0] s);
`ifdef PIPE_AVERAGE_ROUND_EN
    logic [SUM_W:0] r;
    r = {1'b0, s} + (SUM_W+1)'(NUM_CH / 2);
    return DATA_W'(r >> LOG2_CH);
`else
    return DATA_W'(s >> LOG2_CH);
`endif
  endfunction

  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // Adder tree: level s turns NUM_CH>>s sums of DATA_W+s bits into half as many, one bit wider.
  for (genvar s = 0; s < LOG2_CH; s++) begin : g_lvl
    localparam int IW    = DATA_W + s;
    localparam int PAIRS = NUM_CH >> (s + 1);

    logic [2*PAIRS*IW-1:0]   d;
    logic                    v;
    logic [PAIRS*(IW+1)-1:0] q;
    logic                    qv;

    if (s == 0) begin : g_first
      assign d = in_data;
      assign v = in_valid;
    end else begin : g_next
      assign d = g_lvl[s-1].q;
      assign v = g_lvl[s-1].qv;
    end

    pipe_average_stage #(
      .IN_W  (IW),
      .PAIRS (PAIRS)
    ) u_stage (
      .clk     (Clk),
      .rst     (Rst),
      .adv     (adv),
      .in_vld  (v),
      .in_data (d),
      .vld_p   (qv),
      .sum_p   (q)
    );
  end

  logic [SUM_W-1:0] sum_pn;
  logic             vld_pn;
  assign sum_pn = g_lvl[LOG2_CH-1].q;
  assign vld_pn = g_lvl[LOG2_CH-1].qv;

  // Output stage: holds its value while the consumer stalls.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_avg   <= '0;
    end else if (adv) begin
      out_valid <= vld_pn;
      out_sum   <= sum_pn;
      out_avg   <= avg_of(sum_pn);
    end
  end

endmodule

// File: tb/tb_pipe_average.sv
// Scoreboard bench for pipe_average (DATA_W=16, NUM_CH=8); honours PIPE_AVERAGE_ROUND_EN.
module tb_pipe_average;

  localparam int DATA_W  = 16;
  localparam int NUM_CH  = 8;
  localparam int LOG2_CH = 3;
  localparam int SUM_W   = DATA_W + LOG2_CH;
  localparam int LAT     = LOG2_CH + 1;

`ifdef PIPE_AVERAGE_ROUND_EN
  localparam logic [DATA_W-1:0] RAMP_AVG = 16'd4;
`else
  localparam logic [DATA_W-1:0] RAMP_AVG = 16'd3;
`endif

  logic                     Clk = 1'b0;
  logic                     Rst;
  logic                     in_valid;
  logic                     in_ready;
  logic [NUM_CH*DATA_W-1:0] in_data;
  logic                     out_valid;
  logic                     out_ready;
  logic [DATA_W-1:0]        out_avg;
  logic [SUM_W-1:0]         out_sum;

  pipe_average dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_avg   (out_avg),
    .out_sum   (out_sum)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [SUM_W-1:0]  sum;
    logic [DATA_W-1:0] avg;
    int                cyc;
  } exp_t;

  exp_t              sbq[$];
  int                checks   = 0;
  int                failures = 0;
  int                cyc      = 0;
  logic [SUM_W-1:0]  cur_sum;
  logic [DATA_W-1:0] cur_avg;
  logic              hold_prev = 1'b0;
  logic [SUM_W-1:0]  prev_sum;
  logic [DATA_W-1:0] prev_avg;
  logic              last_acc;
  logic              rdy_seen;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h cyc=%0d", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [SUM_W-1:0] m_sum(input logic [NUM_CH*DATA_W-1:0] d);
    logic [SUM_W-1:0] s;
    s = '0;
    for (int k = 0; k < NUM_CH; k++) s += SUM_W'(d[k*DATA_W +: DATA_W]);
    return s;
  endfunction

  function automatic logic [DATA_W-1:0] m_avg(input logic [SUM_W-1:0] s);
`ifdef PIPE_AVERAGE_ROUND_EN
    return DATA_W'(({1'b0, s} + 20'd4) >> 3);
`else
    return DATA_W'(s >> 3);
`endif
  endfunction

  function automatic logic [NUM_CH*DATA_W-1:0] rnd_set();
    logic [NUM_CH*DATA_W-1:0] d;
    for (int k = 0; k < NUM_CH; k++) d[k*DATA_W +: DATA_W] = DATA_W'($urandom);
    return d;
  endfunction

  // One clock: sample/score at negedge, then advance to just after the rising edge.
  task automatic step();
    logic exp_vld;
    exp_t e;
    @(negedge Clk);
    exp_vld = (sbq.size() != 0) && ((cyc - sbq[0].cyc) >= LAT);
    check_val("out_valid", out_valid, exp_vld);
    check_val("in_ready", in_ready, !exp_vld || out_ready);
    if (Rst) begin
      check_val("rst_sum", out_sum, 0);
      check_val("rst_avg", out_avg, 0);
    end
    if (hold_prev) begin
      check_val("hold_valid", out_valid, 1);
      check_val("hold_sum", out_sum, prev_sum);
      check_val("hold_avg", out_avg, prev_avg);
    end
    if (out_valid && out_ready) begin
      if (sbq.size() == 0) begin
        check_val("spurious_out", 1, 0);
      end else begin
        e = sbq.pop_front();
        check_val("out_sum", out_sum, e.sum);
        check_val("out_avg", out_avg, e.avg);
      end
    end
    rdy_seen = in_ready;
    last_acc = in_valid && in_ready;
    if (last_acc) sbq.push_back('{sum: cur_sum, avg: cur_avg, cyc: cyc});
    hold_prev = out_valid && !out_ready;
    prev_sum  = out_sum;
    prev_avg  = out_avg;
    @(posedge Clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b0;
      in_data  = rnd_set();
      step();
    end
  endtask

  task automatic send(input logic [NUM_CH*DATA_W-1:0] d, input logic [SUM_W-1:0] s,
                      input logic [DATA_W-1:0] a);
    int tries;
    tries    = 0;
    in_valid = 1'b1;
    in_data  = d;
    cur_sum  = s;
    cur_avg  = a;
    step();
    while (!last_acc && tries < 20) begin
      step();
      tries++;
    end
    if (!last_acc) check_val("send_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic send_rnd();
    logic [NUM_CH*DATA_W-1:0] d;
    d = rnd_set();
    send(d, m_sum(d), m_avg(m_sum(d)));
  endtask

  logic [NUM_CH*DATA_W-1:0] dset [10];
  logic [NUM_CH*DATA_W-1:0] dtmp;
  int                       idx;

  initial begin
    Rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    cur_sum   = '0;
    cur_avg   = '0;
    step();
    step();
    Rst = 1'b0;
    idle(2);

    // Directed values
    for (int k = 0; k < NUM_CH; k++) dtmp[k*DATA_W +: DATA_W] = 16'd8;
    send(dtmp, 19'd64, 16'd8);
    idle(6);
    for (int k = 0; k < NUM_CH; k++) dtmp[k*DATA_W +: DATA_W] = DATA_W'(k);
    send(dtmp, 19'd28, RAMP_AVG);
    idle(6);
    for (int k = 0; k < NUM_CH; k++) dtmp[k*DATA_W +: DATA_W] = 16'hFFFF;
    send(dtmp, 19'h7FFF8, 16'hFFFF);
    idle(6);

    // Back-to-back sets with a three-cycle consumer stall
    for (int i = 0; i < 10; i++) dset[i] = rnd_set();
    idx = 0;
    for (int t = 0; t < 40 && idx < 10; t++) begin
      in_valid  = 1'b1;
      in_data   = dset[idx];
      cur_sum   = m_sum(dset[idx]);
      cur_avg   = m_avg(cur_sum);
      out_ready = !(t >= 6 && t <= 8);
      step();
      check_val("stall_in_ready", rdy_seen, !(t >= 6 && t <= 8));
      if (last_acc) idx++;
    end
    out_ready = 1'b1;
    if (idx < 10) check_val("stall_timeout", idx, 10);
    idle(8);

    // Alternating valid/bubble
    for (int i = 0; i < 6; i++) begin
      send_rnd();
      idle(1);
    end
    idle(6);

    // Full-rate burst
    for (int i = 0; i < 12; i++) send_rnd();
    idle(6);

    // Reset while three sets are in flight
    for (int i = 0; i < 3; i++) send_rnd();
    idle(1);
    Rst = 1'b1;
    sbq.delete();
    hold_prev = 1'b0;
    step();
    Rst = 1'b0;
    idle(8);

    // Recovery after reset
    for (int i = 0; i < 4; i++) send_rnd();
    idle(8);

    check_val("sb_empty", sbq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
